// File: rtl/fetch_stage.sv
// fetch_stage: RV32I instruction-fetch stage with IF/ID pipeline register.
// Keeps the fetch PC, runs a req/ack handshake with instruction memory,
// buffers a response that arrives while decode is stalled, and throws away
// any response still in flight when execute redirects the PC.
// Optional build macro FETCH_PERF_CNT_EN adds perf_fetched / perf_bubbles.
module fetch_stage #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   input  logic        stall,
   input  logic        br_taken,
   input  logic [31:0] br_target,
   output logic        if_valid,
   output logic [31:0] if_inst,
   output logic [31:0] if_pc
`ifdef FETCH_PERF_CNT_EN
   ,
   output logic [31:0] perf_fetched,
   output logic [31:0] perf_bubbles
`endif
);

   // IDLE: one quiet cycle out of reset; REQ: request pc; HOLD: response
   // parked in hold_inst while decode stalls; DROP: wait out a stale request.
   typedef enum logic [1:0] {IDLE, REQ, HOLD, DROP} state_t;

   state_t      state, state_nxt;
   logic [31:0] pc, pc_nxt;
   logic [31:0] req_addr, req_addr_nxt;
   logic [31:0] hold_inst, hold_inst_nxt;
   logic        if_valid_nxt;
   logic [31:0] if_inst_nxt, if_pc_nxt;
   logic [31:0] tgt;

   // Redirect targets are always word aligned.
   assign tgt = {br_target[31:2], 2'b00};

   // Next-state, next register values and memory-side outputs.
   always_comb begin
      state_nxt     = state;
      pc_nxt        = pc;
      req_addr_nxt  = req_addr;
      hold_inst_nxt = hold_inst;
      if_valid_nxt  = if_valid;
      if_inst_nxt   = if_inst;
      if_pc_nxt     = if_pc;
      imem_req      = 1'b0;
      imem_addr     = pc;
      case (state)
         IDLE: begin
            state_nxt = REQ;
            if (br_taken) begin
               pc_nxt       = tgt;
               if_valid_nxt = 1'b0;
               if_inst_nxt  = NOP_INST;
            end
         end
         REQ: begin
            imem_req = 1'b1;
            if (br_taken) begin
               pc_nxt       = tgt;
               if_valid_nxt = 1'b0;
               if_inst_nxt  = NOP_INST;
               // A request that is not answered this cycle is still owed by
               // memory; remember its address and swallow the reply in DROP.
               if (!imem_ack) begin
                  req_addr_nxt = pc;
                  state_nxt    = DROP;
               end
            end else if (imem_ack && !stall) begin
               if_inst_nxt  = imem_rdata;
               if_pc_nxt    = pc;
               if_valid_nxt = 1'b1;
               pc_nxt       = pc + 32'd4;
            end else if (imem_ack) begin
               hold_inst_nxt = imem_rdata;
               state_nxt     = HOLD;
            end else if (!stall) begin
               if_valid_nxt = 1'b0;
               if_inst_nxt  = NOP_INST;
            end
         end
         HOLD: begin
            if (br_taken) begin
               pc_nxt       = tgt;
               if_valid_nxt = 1'b0;
               if_inst_nxt  = NOP_INST;
               state_nxt    = REQ;
            end else if (!stall) begin
               // pc was not advanced on the buffered ack, so it is still the
               // address of hold_inst.
               if_inst_nxt  = hold_inst;
               if_pc_nxt    = pc;
               if_valid_nxt = 1'b1;
               pc_nxt       = pc + 32'd4;
               state_nxt    = REQ;
            end
         end
         DROP: begin
            imem_req     = 1'b1;
            imem_addr    = req_addr;
            if_valid_nxt = 1'b0;
            if_inst_nxt  = NOP_INST;
            if (br_taken) pc_nxt = tgt;
            if (imem_ack) state_nxt = REQ;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // FSM state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // PC, outstanding-request address and IF/ID register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc       <= RESET_PC;
         req_addr <= RESET_PC;
         if_valid <= 1'b0;
         if_inst  <= NOP_INST;
         if_pc    <= 32'd0;
      end else begin
         pc       <= pc_nxt;
         req_addr <= req_addr_nxt;
         if_valid <= if_valid_nxt;
         if_inst  <= if_inst_nxt;
         if_pc    <= if_pc_nxt;
      end
   end

   // Skid buffer for a response accepted while decode is stalled.
   always_ff @(posedge clk) begin
      hold_inst <= hold_inst_nxt;
   end

`ifdef FETCH_PERF_CNT_EN
   logic perf_load;
   assign perf_load = !br_taken && !stall &&
                      ((state == REQ && imem_ack) || state == HOLD);

   // Fetched-instruction and bubble counters, free-running modulo 2^32.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         perf_fetched <= 32'd0;
         perf_bubbles <= 32'd0;
      end else begin
         if (perf_load)          perf_fetched <= perf_fetched + 32'd1;
         if (!if_valid && !stall) perf_bubbles <= perf_bubbles + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: randomized bench for fetch_stage with a memory responder,
// a stimulus driver that queues the expected instruction stream, and an
// independent monitor that pops and compares whatever decode is shown.
module tb_fetch_stage;

   localparam logic [31:0] RESET_PC = 32'h0000_0000;
   localparam logic [31:0] NOP_INST = 32'h0000_0013;

   logic        clk;
   logic        rst_n;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic        stall;
   logic        br_taken;
   logic [31:0] br_target;
   logic        if_valid;
   logic [31:0] if_inst;
   logic [31:0] if_pc;
`ifdef FETCH_PERF_CNT_EN
   logic [31:0] perf_fetched;
   logic [31:0] perf_bubbles;
`endif

   fetch_stage #(.RESET_PC(RESET_PC), .NOP_INST(NOP_INST)) dut (
      .clk(clk), .rst_n(rst_n),
      .imem_req(imem_req), .imem_addr(imem_addr),
      .imem_ack(imem_ack), .imem_rdata(imem_rdata),
      .stall(stall), .br_taken(br_taken), .br_target(br_target),
      .if_valid(if_valid), .if_inst(if_inst), .if_pc(if_pc)
`ifdef FETCH_PERF_CNT_EN
      , .perf_fetched(perf_fetched), .perf_bubbles(perf_bubbles)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_cmp  = 0;
   int n_fail = 0;

   // Expected stream of {pc, instruction} in program order.
   logic [63:0] exp_q[$];
   logic [31:0] gen_pc;
   logic        last_br;
   logic [31:0] last_tgt;

   int unsigned lat_lo = 0;
   int unsigned lat_hi = 0;
   int          m_fetched = 0;
   int          m_bub = 0;

   function automatic logic [31:0] word(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // One clock of stimulus; a redirect sampled at this edge restarts the
   // expected program stream at its word-aligned target.
   task automatic step(input logic s, input logic b, input logic [31:0] t);
      @(posedge clk);
      #1;
      if (last_br) begin
         exp_q.delete();
         gen_pc = last_tgt & 32'hFFFF_FFFC;
      end
      while (exp_q.size() < 4) begin
         exp_q.push_back({gen_pc, word(gen_pc)});
         gen_pc = gen_pc + 32'd4;
      end
      stall     = s;
      br_taken  = b;
      br_target = t;
      last_br   = b;
      last_tgt  = t;
   endtask

   task automatic model_reset();
      exp_q.delete();
      gen_pc  = RESET_PC;
      last_br = 1'b0;
   endtask

   // Memory responder: random latency per request, address must stay put.
   logic        busy = 1'b0;
   int unsigned wait_cnt = 0;
   logic [31:0] addr_q = 32'd0;
   initial begin
      imem_ack   = 1'b0;
      imem_rdata = 32'd0;
      forever begin
         @(posedge clk);
         #1;
         if (!rst_n) begin
            busy     = 1'b0;
            imem_ack = 1'b0;
         end else if (imem_req) begin
            if (!busy) begin
               busy     = 1'b1;
               wait_cnt = $urandom_range(lat_hi, lat_lo);
               addr_q   = imem_addr;
            end else begin
               check("addr_stable", imem_addr, addr_q);
            end
            if (wait_cnt == 0) begin
               imem_ack   = 1'b1;
               imem_rdata = word(imem_addr);
               busy       = 1'b0;
            end else begin
               imem_ack   = 1'b0;
               imem_rdata = $urandom;
               wait_cnt--;
            end
         end else begin
            if (busy) check("req_held", {31'd0, imem_req}, 32'd1);
            busy     = 1'b0;
            imem_ack = 1'b0;
         end
      end
   end

   // Monitor: judges each edge by the stall/redirect it sampled.
   logic        have_prev = 1'b0;
   logic        e_stall = 1'b0, e_br = 1'b0;
   logic        p_valid = 1'b0;
   logic [31:0] p_inst = 32'd0, p_pc = 32'd0;
   int          idle_cnt = 0;
   initial begin
      logic [63:0] e;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            have_prev = 1'b0;
            idle_cnt  = 0;
            m_fetched = 0;
            m_bub     = 0;
         end else begin
            idle_cnt++;
            if (!have_prev) begin
               check("rst_valid", {31'd0, if_valid}, 32'd0);
               check("rst_inst", if_inst, NOP_INST);
               check("rst_pc", if_pc, 32'd0);
               check("rst_req", {31'd0, imem_req}, 32'd0);
            end else if (e_br) begin
               check("flush_valid", {31'd0, if_valid}, 32'd0);
               check("flush_inst", if_inst, NOP_INST);
               idle_cnt = 0;
            end else if (e_stall) begin
               check("stall_valid", {31'd0, if_valid}, {31'd0, p_valid});
               check("stall_inst", if_inst, p_inst);
               check("stall_pc", if_pc, p_pc);
            end else if (if_valid) begin
               if (exp_q.size() == 0) begin
                  n_cmp++;
                  n_fail++;
                  $display("FAIL sb_empty: got pc %h with nothing expected", if_pc);
               end else begin
                  e = exp_q.pop_front();
                  check("if_pc", if_pc, e[63:32]);
                  check("if_inst", if_inst, e[31:0]);
               end
               m_fetched++;
               idle_cnt = 0;
            end else begin
               check("bubble_inst", if_inst, NOP_INST);
            end
            if (idle_cnt > 300) begin
               n_cmp++;
               n_fail++;
               $display("FAIL progress: got %0d idle cycles expected at most 300", idle_cnt);
               idle_cnt = 0;
            end
            p_valid   = if_valid;
            p_inst    = if_inst;
            p_pc      = if_pc;
            e_stall   = stall;
            e_br      = br_taken;
            have_prev = 1'b1;
            if (!if_valid && !stall) m_bub++;
         end
      end
   end

   initial begin
      #3_000_000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end

   // Stimulus sequence.
   initial begin
      logic        s, b, found;
      logic [31:0] t;
      rst_n = 1'b0;
      stall = 1'b0;
      br_taken = 1'b0;
      br_target = 32'd0;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
      model_reset();

      // zero-wait memory, free-running fetch
      lat_lo = 0; lat_hi = 0;
      repeat (20) step(1'b0, 1'b0, 32'd0);

      // two-cycle memory latency
      lat_lo = 2; lat_hi = 2;
      repeat (20) step(1'b0, 1'b0, 32'd0);

      // stall held across an ack
      lat_lo = 0; lat_hi = 0;
      repeat (2) step(1'b0, 1'b0, 32'd0);
      repeat (3) step(1'b1, 1'b0, 32'd0);
      repeat (6) step(1'b0, 1'b0, 32'd0);

      // redirect while a slow request is outstanding
      lat_lo = 3; lat_hi = 3;
      step(1'b0, 1'b1, 32'h0000_0010);
      step(1'b0, 1'b0, 32'd0);
      step(1'b0, 1'b1, 32'h0000_0103);
      repeat (20) step(1'b0, 1'b0, 32'd0);

      // PC wrap at the top of the address space
      lat_lo = 0; lat_hi = 0;
      step(1'b0, 1'b1, 32'hFFFF_FFFC);
      repeat (8) step(1'b0, 1'b0, 32'd0);

      // random mix of latency, stall and redirects
      lat_lo = 0; lat_hi = 3;
      for (int i = 0; i < 2000; i++) begin
         s = ($urandom_range(99, 0) < 25);
         b = ($urandom_range(99, 0) < 5);
         case ($urandom_range(3, 0))
            0:       t = 32'h0000_0103;
            1:       t = 32'hFFFF_FFF8 | ($urandom & 32'h7);
            default: t = $urandom;
         endcase
         step(s, b, t);
      end
      repeat (4) step(1'b0, 1'b0, 32'd0);

      // async reset while a response is parked in the skid buffer
      lat_lo = 0; lat_hi = 0;
      found = 1'b0;
      for (int i = 0; i < 10 && !found; i++) begin
         step(1'b1, 1'b0, 32'd0);
         if (!imem_req) found = 1'b1;
      end
      check("hold_reached", {31'd0, found}, 32'd1);
      #2;
      rst_n = 1'b0;
      stall = 1'b0;
      last_br = 1'b0;
      #1;
      check("arst_valid", {31'd0, if_valid}, 32'd0);
      check("arst_inst", if_inst, NOP_INST);
      check("arst_req", {31'd0, imem_req}, 32'd0);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      model_reset();
      found = 1'b0;
      for (int i = 0; i < 5 && !found; i++) begin
         step(1'b0, 1'b0, 32'd0);
         if (imem_req) begin
            found = 1'b1;
            check("first_req_addr", imem_addr, RESET_PC);
         end
      end
      check("first_req_seen", {31'd0, found}, 32'd1);
      repeat (10) step(1'b0, 1'b0, 32'd0);

      // quiesce so the counters and the model line up
      repeat (3) step(1'b1, 1'b0, 32'd0);
`ifdef FETCH_PERF_CNT_EN
      check("perf_fetched", perf_fetched, m_fetched);
      check("perf_bubbles", perf_bubbles, m_bub);
`endif
      check("sb_drained_min", {31'd0, (m_fetched > 0)}, 32'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
